train_sequencer: RTL and testbench

Training-loop controller for the 4-input / 8-hidden / 1-output network. It sequences accumulator clears, the forward pass and backpropagation for a configurable number of epochs. It time-multiplexes one shared output backprop unit across the 8 hidden-to-output weights and owns the 8×8-bit weight bank that feeds the output neuron. It replaces the hard-wired weight muxing and one-weight backprop hookup at top level.

---
 rtl/train_pkg.sv | 25 ++
 rtl/stage_watchdog.sv | 28 ++
 rtl/train_sequencer.sv | 177 +++++++++++++++++
 tb/tb_train_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
// Shared types and constants for the training-loop sequencer.
// Pure declarations; no timing or flow control.
package train_pkg;

  localparam int NUM_W   = 8;
  localparam int W_WIDTH = 8;

  // Weight i resets to i+1; weight 0 sits in the least-significant byte.
  localparam logic [NUM_W*W_WIDTH-1:0] INIT_WEIGHTS = 64'h0807_0605_0403_0201;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FWD,
    BP,
    BP_GAP,
    EPOCH_END,
    DONE
  } state_t;

  function automatic int bank_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Cycle counter for one FWD or BP stage; tc is high during the TIMEOUT-th cycle
// of a stage. Clear wins over enable. No backpressure.
module stage_watchdog #(
  parameter int TIMEOUT = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt is 0 in the first cycle of a stage, so TIMEOUT-1 marks the last allowed cycle.
  assign tc = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/train_sequencer.sv
// Epoch/forward/backprop sequencer owning the hidden-to-output weight bank.
// Control latency one cycle per transition; end strobes are sampled only in their own state.
module train_sequencer #(
  parameter int NUM_W   = train_pkg::NUM_W,
  parameter int W_WIDTH = train_pkg::W_WIDTH,
  parameter int TIMEOUT = 63
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [3:0]                 epochs_i,
  input  logic                       f_end_i,
  input  logic                       b_end_i,
  input  logic [W_WIDTH-1:0]         w_bp_i,
  output logic                       zero_loss_o,
  output logic                       zero_final_o,
  output logic                       f_en_o,
  output logic                       bp_en_o,
  output logic                       zero_bp_o,
  output logic [$clog2(NUM_W)-1:0]   bp_sel_o,
  output logic [W_WIDTH-1:0]         bp_w_o,
  output logic [NUM_W*W_WIDTH-1:0]   weights_o,
  output logic [3:0]                 epoch_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  import train_pkg::*;

  localparam int SEL_W = $clog2(NUM_W);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_W - 1);

  state_t                     state;
  logic [3:0]                 epochs_q;
  logic [NUM_W*W_WIDTH-1:0]   weights_q;
  logic                       wd_en;
  logic                       wd_clr;
  logic                       wd_tc;

  // The counter restarts on every entry to FWD or BP; FWD->BP is the only
  // direct hop between watched states, so it needs an explicit clear.
  assign wd_en  = (state == FWD) || (state == BP);
  assign wd_clr = !wd_en || ((state == FWD) && f_end_i);

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk (clk_i),
    .rst (rst_i),
    .clr (wd_clr),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  assign weights_o = weights_q;
  assign bp_w_o    = weights_q[bank_lsb(int'(bp_sel_o), W_WIDTH) +: W_WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      epochs_q     <= '0;
      weights_q    <= (NUM_W*W_WIDTH)'(INIT_WEIGHTS);
      zero_loss_o  <= 1'b0;
      zero_final_o <= 1'b0;
      f_en_o       <= 1'b0;
      bp_en_o      <= 1'b0;
      zero_bp_o    <= 1'b0;
      bp_sel_o     <= '0;
      epoch_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      zero_loss_o  <= 1'b0;
      zero_final_o <= 1'b0;
      zero_bp_o    <= 1'b0;
      done_o       <= 1'b0;

      if (abort_i && (state != IDLE)) begin
        state   <= IDLE;
        f_en_o  <= 1'b0;
        bp_en_o <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              epochs_q <= epochs_i;
              epoch_o  <= '0;
              err_o    <= 1'b0;
              busy_o   <= 1'b1;
              if (epochs_i != 4'd0) begin
                state        <= CLEAR;
                zero_loss_o  <= 1'b1;
                zero_final_o <= 1'b1;
              end else begin
                state  <= DONE;
                done_o <= 1'b1;
              end
            end
          end

          CLEAR: begin
            state  <= FWD;
            f_en_o <= 1'b1;
          end

          FWD: begin
            if (f_end_i) begin
              state     <= BP;
              f_en_o    <= 1'b0;
              bp_en_o   <= 1'b1;
              bp_sel_o  <= '0;
              zero_bp_o <= 1'b1;
            end else if (wd_tc) begin
              state  <= IDLE;
              f_en_o <= 1'b0;
              busy_o <= 1'b0;
              err_o  <= 1'b1;
            end
          end

          BP: begin
            if (b_end_i) begin
              weights_q[bank_lsb(int'(bp_sel_o), W_WIDTH) +: W_WIDTH] <= w_bp_i;
              bp_en_o <= 1'b0;
              if (bp_sel_o == LAST_SEL) begin
                state <= EPOCH_END;
              end else begin
                state     <= BP_GAP;
                zero_bp_o <= 1'b1;
              end
            end else if (wd_tc) begin
              state   <= IDLE;
              bp_en_o <= 1'b0;
              busy_o  <= 1'b0;
              err_o   <= 1'b1;
            end
          end

          BP_GAP: begin
            state    <= BP;
            bp_en_o  <= 1'b1;
            bp_sel_o <= bp_sel_o + SEL_W'(1);
          end

          EPOCH_END: begin
            epoch_o <= epoch_o + 4'd1;
            if ((epoch_o + 4'd1) == epochs_q) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state        <= CLEAR;
              zero_loss_o  <= 1'b1;
              zero_final_o <= 1'b1;
            end
          end

          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end

          default: begin
            state   <= IDLE;
            f_en_o  <= 1'b0;
            bp_en_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: expected bp_sel walks and run results are
// queued at stimulus time and compared by an independent output monitor.
module tb_train_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  epochs_i = 4'd0;
  logic        f_end_i = 1'b0;
  logic        b_end_i = 1'b0;
  logic [7:0]  w_bp_i = 8'd0;
  logic        zero_loss_o, zero_final_o, f_en_o, bp_en_o, zero_bp_o;
  logic [2:0]  bp_sel_o;
  logic [7:0]  bp_w_o;
  logic [63:0] weights_o;
  logic [3:0]  epoch_o;
  logic        busy_o, done_o, err_o;

  train_sequencer #(.NUM_W(8), .W_WIDTH(8), .TIMEOUT(63)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .epochs_i     (epochs_i),
    .f_end_i      (f_end_i),
    .b_end_i      (b_end_i),
    .w_bp_i       (w_bp_i),
    .zero_loss_o  (zero_loss_o),
    .zero_final_o (zero_final_o),
    .f_en_o       (f_en_o),
    .bp_en_o      (bp_en_o),
    .zero_bp_o    (zero_bp_o),
    .bp_sel_o     (bp_sel_o),
    .bp_w_o       (bp_w_o),
    .weights_o    (weights_o),
    .epoch_o      (epoch_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic [3:0]  epoch;
    logic [63:0] w;
  } done_exp_t;

  done_exp_t  done_q[$];
  logic [2:0] sel_q[$];
  logic [7:0] mw[8];

  int pass_cnt = 0, total_cnt = 0;
  int zl_cnt = 0, zf_cnt = 0, fen_rise = 0, fen_cyc = 0, gap_cnt = 0, done_cnt = 0, zbp_cnt = 0;
  logic f_en_prev = 1'b0, bp_en_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [63:0] wvec(input logic [7:0] base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  // Output monitor: pops expectations whenever the DUT presents a BP entry or done.
  always begin
    @(posedge clk);
    #1;
    if (rst_i === 1'b0) begin
      if (zero_loss_o) zl_cnt++;
      if (zero_final_o) zf_cnt++;
      if (f_en_o && !f_en_prev) fen_rise++;
      if (f_en_o) fen_cyc++;
      if (zero_bp_o) zbp_cnt++;
      if (zero_bp_o && !bp_en_o) gap_cnt++;
      if (bp_en_o && !bp_en_prev) begin
        check("bp_entry_expected", 64'(sel_q.size() != 0), 64'd1);
        if (sel_q.size() != 0) check("bp_sel_walk", 64'(bp_sel_o), 64'(sel_q.pop_front()));
      end
      if (done_o) begin
        done_exp_t e;
        done_cnt++;
        check("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          check("done_epoch", 64'(epoch_o), 64'(e.epoch));
          check("done_weights", weights_o, e.w);
        end
      end
      f_en_prev  = f_en_o;
      bp_en_prev = bp_en_o;
    end
  end

  task automatic push_sel(input int n_epochs, input int upto);
    for (int e = 0; e < n_epochs; e++)
      for (int s = 0; s <= upto; s++) sel_q.push_back(3'(s));
  endtask

  task automatic push_done(input logic [3:0] ep, input logic [63:0] w);
    done_exp_t e;
    e.epoch = ep;
    e.w = w;
    done_q.push_back(e);
  endtask

  // Starts a run and plays the forward/backprop units until busy_o falls.
  task automatic run(input logic [3:0] ep, input int f_lat, input int b_lat, input logic [7:0] wbase,
                     input int abort_sel, input int spur_sel, input int rst_sel,
                     output int done_at, output int ffen, output int ev_at, output int end_at,
                     output int b_acc, output logic first_ok);
    int cyc = 0, fcnt = 0, bcnt = 0;
    done_at = -1; ffen = -1; ev_at = -1; b_acc = 0; first_ok = 1'b0;
    @(negedge clk);
    start_i = 1'b1; epochs_i = ep;
    @(negedge clk);
    start_i = 1'b0;
    while (busy_o === 1'b1 && cyc < 2000) begin
      if (cyc == 0) first_ok = zero_loss_o && zero_final_o && !err_o;
      if (done_o && done_at < 0) done_at = cyc;
      if (f_en_o && ffen < 0) ffen = cyc;
      f_end_i = 1'b0; b_end_i = 1'b0; abort_i = 1'b0; start_i = 1'b0; rst_i = 1'b0;
      if (f_en_o) begin
        fcnt++;
        if (fcnt == f_lat) f_end_i = 1'b1;
      end else fcnt = 0;
      if (bp_en_o) begin
        bcnt++;
        if (int'(bp_sel_o) == spur_sel) begin start_i = 1'b1; epochs_i = 4'd5; end
        if (int'(bp_sel_o) == rst_sel) begin
          rst_i = 1'b1; ev_at = cyc;
        end else if (bcnt == b_lat) begin
          check("bp_w_read", 64'(bp_w_o), 64'(mw[bp_sel_o]));
          b_end_i = 1'b1;
          w_bp_i  = wbase + 8'(bp_sel_o);
          if (int'(bp_sel_o) == abort_sel) begin
            abort_i = 1'b1; ev_at = cyc;
          end else begin
            mw[bp_sel_o] = w_bp_i; b_acc++;
          end
        end
      end else bcnt = 0;
      @(negedge clk);
      cyc++;
    end
    check("run_terminates", 64'(busy_o), 64'd0);
    end_at = cyc;
    f_end_i = 1'b0; b_end_i = 1'b0; abort_i = 1'b0; start_i = 1'b0; rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int done_at, ffen, ev_at, end_at, b_acc;
    logic first_ok;
    int s_zl, s_zf, s_fr, s_fc, s_gap, s_done, s_zbp;
    logic [63:0] wexp, wlo;

    for (int i = 0; i < 8; i++) mw[i] = 8'(i + 1);

    // Reset with a start request held: reset must win.
    start_i = 1'b1; epochs_i = 4'd1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_f_en", 64'(f_en_o), 64'd0);
    check("rst_bp_en", 64'(bp_en_o), 64'd0);
    check("rst_zero_strobes", {61'd0, zero_loss_o, zero_final_o, zero_bp_o}, 64'd0);
    check("rst_bp_sel", 64'(bp_sel_o), 64'd0);
    check("rst_epoch", 64'(epoch_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_weights", weights_o, 64'h0807_0605_0403_0201);
    check("rst_bp_w", 64'(bp_w_o), 64'd1);
    start_i = 1'b0; epochs_i = 4'd0; rst_i = 1'b0;
    @(negedge clk);

    // epochs=0: immediate done, no forward pass.
    s_fr = fen_rise; s_done = done_cnt;
    push_done(4'd0, wvec(8'h01));
    run(4'd0, 3, 2, 8'h00, -1, -1, -1, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    check("ep0_done_at", 64'(done_at), 64'd0);
    check("ep0_no_fwd", 64'(fen_rise - s_fr), 64'd0);
    check("ep0_done_count", 64'(done_cnt - s_done), 64'd1);
    check("ep0_weights", weights_o, 64'h0807_0605_0403_0201);

    // One epoch, F=3, B=2, w = 0x10+sel.
    s_zl = zl_cnt; s_gap = gap_cnt; s_done = done_cnt;
    push_sel(1, 7);
    push_done(4'd1, 64'h1716_1514_1312_1110);
    run(4'd1, 3, 2, 8'h10, -1, -1, -1, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    check("ep1_start_strobes", 64'(first_ok), 64'd1);
    check("ep1_first_f_en", 64'(ffen), 64'd1);
    check("ep1_done_at", 64'(done_at), 64'd28);
    check("ep1_busy_fall", 64'(end_at - done_at), 64'd1);
    check("ep1_gaps", 64'(gap_cnt - s_gap), 64'd7);
    check("ep1_clears", 64'(zl_cnt - s_zl), 64'd1);
    check("ep1_b_acc", 64'(b_acc), 64'd8);
    check("ep1_done_count", 64'(done_cnt - s_done), 64'd1);
    check("ep1_epoch", 64'(epoch_o), 64'd1);

    // Three epochs, w = 0x20+sel.
    s_zl = zl_cnt; s_zf = zf_cnt; s_fr = fen_rise; s_done = done_cnt;
    push_sel(3, 7);
    push_done(4'd3, 64'h2726_2524_2322_2120);
    run(4'd3, 3, 2, 8'h20, -1, -1, -1, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    check("ep3_done_at", 64'(done_at), 64'd84);
    check("ep3_zero_loss", 64'(zl_cnt - s_zl), 64'd3);
    check("ep3_zero_final", 64'(zf_cnt - s_zf), 64'd3);
    check("ep3_fwd_passes", 64'(fen_rise - s_fr), 64'd3);
    check("ep3_b_acc", 64'(b_acc), 64'd24);
    check("ep3_done_count", 64'(done_cnt - s_done), 64'd1);
    check("ep3_epoch", 64'(epoch_o), 64'd3);

    // Forward pass never ends: watchdog after 63 FWD cycles.
    s_fc = fen_cyc; s_done = done_cnt;
    run(4'd1, 0, 2, 8'h30, -1, -1, -1, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    check("to_err", 64'(err_o), 64'd1);
    check("to_fwd_cycles", 64'(fen_cyc - s_fc), 64'd63);
    check("to_no_done", 64'(done_cnt - s_done), 64'd0);
    check("to_done_at", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_weights", weights_o, 64'h2726_2524_2322_2120);

    // Next start clears err.
    push_sel(1, 7);
    push_done(4'd1, 64'h3736_3534_3332_3130);
    run(4'd1, 3, 2, 8'h30, -1, -1, -1, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    check("recover_err_clear", 64'(first_ok), 64'd1);
    check("recover_err_end", 64'(err_o), 64'd0);

    // Abort coincident with b_end at sel 4.
    s_done = done_cnt;
    push_sel(1, 4);
    run(4'd1, 3, 2, 8'h40, 4, -1, -1, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    wexp = wvec(8'h30);
    wlo  = wvec(8'h40);
    wexp[31:0] = wlo[31:0];
    check("abort_idle_next", 64'(end_at - ev_at), 64'd1);
    check("abort_weights", weights_o, wexp);
    check("abort_no_done", 64'(done_cnt - s_done), 64'd0);
    check("abort_bp_en", 64'(bp_en_o), 64'd0);

    // Spurious end strobes in IDLE.
    s_zbp = zbp_cnt;
    f_end_i = 1'b1; b_end_i = 1'b1; w_bp_i = 8'hEE;
    repeat (3) @(negedge clk);
    f_end_i = 1'b0; b_end_i = 1'b0;
    check("spur_idle_busy", 64'(busy_o), 64'd0);
    check("spur_idle_enables", {62'd0, f_en_o, bp_en_o}, 64'd0);
    check("spur_idle_zbp", 64'(zbp_cnt - s_zbp), 64'd0);
    check("spur_idle_weights", weights_o, wexp);

    // start_i during BP is ignored.
    push_sel(1, 7);
    push_done(4'd1, 64'h5756_5554_5352_5150);
    run(4'd1, 3, 2, 8'h50, -1, 2, -1, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    check("spur_start_done_at", 64'(done_at), 64'd28);
    check("spur_start_epoch", 64'(epoch_o), 64'd1);

    // Reset during BP at sel 3.
    push_sel(1, 3);
    run(4'd2, 3, 2, 8'h60, -1, -1, 3, done_at, ffen, ev_at, end_at, b_acc, first_ok);
    for (int i = 0; i < 8; i++) mw[i] = 8'(i + 1);
    check("mid_rst_weights", weights_o, 64'h0807_0605_0403_0201);
    check("mid_rst_sel", 64'(bp_sel_o), 64'd0);
    check("mid_rst_epoch", 64'(epoch_o), 64'd0);
    check("mid_rst_enables", {61'd0, f_en_o, bp_en_o, zero_bp_o}, 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);

    @(negedge clk);
    check("sel_q_drained", 64'(sel_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
